// File: rtl/glb_tile_pcfg_dma_ctrl.sv
// Parallel-config DMA for one GLB tile: fetches 64-bit bitstream words from the bank and emits CGRA config writes.
// Optional performance counters are enabled by defining GLB_PC_DMA_PERF_EN.
module glb_tile_pcfg_dma_ctrl #(
  parameter int GLB_ADDR_WIDTH      = 22,
  parameter int BANK_DATA_WIDTH     = 64,
  parameter int CGRA_CFG_ADDR_WIDTH = 32,
  parameter int CGRA_CFG_DATA_WIDTH = 32,
  parameter int MAX_NUM_CFG_WIDTH   = 16,
  parameter int QUEUE_DEPTH         = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cfg_pc_dma_mode,
  input  logic [GLB_ADDR_WIDTH-1:0]      cfg_pc_start_addr,
  input  logic [MAX_NUM_CFG_WIDTH-1:0]   cfg_pc_num_cfg,
  input  logic                           pc_start_pulse,
  output logic                           pc_busy,
  output logic                           pc_done_pulse,
  output logic                           rdrq_en,
  output logic [GLB_ADDR_WIDTH-1:0]      rdrq_addr,
  input  logic                           rdrq_ready,
  input  logic                           rdrs_valid,
  input  logic [BANK_DATA_WIDTH-1:0]     rdrs_data,
  input  logic                           cfg_stall,
  output logic                           cgra_cfg_c2sw_wr_en,
  output logic                           cgra_cfg_c2sw_rd_en,
  output logic [CGRA_CFG_ADDR_WIDTH-1:0] cgra_cfg_c2sw_addr,
  output logic [CGRA_CFG_DATA_WIDTH-1:0] cgra_cfg_c2sw_data,
  output logic                           pc_err_unexp_rdrs
`ifdef GLB_PC_DMA_PERF_EN
  ,
  output logic [31:0]                    pc_dma_cycles,
  output logic [15:0]                    pc_dma_stall_cycles
`endif
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                   state;
  logic [GLB_ADDR_WIDTH-1:0]    base_q;
  logic [MAX_NUM_CFG_WIDTH-1:0] num_cfg_q;
  logic [MAX_NUM_CFG_WIDTH-1:0] req_cnt;
  logic [MAX_NUM_CFG_WIDTH-1:0] wr_cnt;
  logic [CNT_W-1:0]             outstanding;
  logic [CNT_W-1:0]             occupancy;
  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             rd_ptr;
  logic [BANK_DATA_WIDTH-1:0]   queue_mem [QUEUE_DEPTH];

  logic [CNT_W:0]               credit_used;
  logic [GLB_ADDR_WIDTH-1:0]    req_off;
  logic [BANK_DATA_WIDTH-1:0]   rd_word;
  logic                         start_fire;
  logic                         req_accept;
  logic                         push;
  logic                         pop;

  // Credits count both in-flight requests and queued words, so a response always finds a free slot.
  assign credit_used = {1'b0, outstanding} + {1'b0, occupancy};
  assign rdrq_en     = (state == S_RUN) && (req_cnt < num_cfg_q) &&
                       (credit_used < (CNT_W+1)'(QUEUE_DEPTH));
  assign req_off     = GLB_ADDR_WIDTH'({req_cnt, 3'b000});
  assign rdrq_addr   = rdrq_en ? (base_q + req_off) : '0;

  assign start_fire = (state == S_IDLE) && pc_start_pulse && cfg_pc_dma_mode;
  assign req_accept = rdrq_en && rdrq_ready;
  assign push       = rdrs_valid && (outstanding != '0);
  assign pop        = (occupancy != '0) && !cfg_stall;
  assign rd_word    = queue_mem[rd_ptr];

  assign pc_busy             = (state != S_IDLE);
  assign pc_done_pulse       = (state == S_DONE);
  assign cgra_cfg_c2sw_rd_en = 1'b0;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      base_q    <= '0;
      num_cfg_q <= '0;
      req_cnt   <= '0;
      wr_cnt    <= '0;
    end else begin
      if (req_accept) req_cnt <= req_cnt + MAX_NUM_CFG_WIDTH'(1);
      if (pop)        wr_cnt  <= wr_cnt + MAX_NUM_CFG_WIDTH'(1);
      case (state)
        S_IDLE: begin
          if (start_fire) begin
            base_q    <= cfg_pc_start_addr;
            num_cfg_q <= cfg_pc_num_cfg;
            req_cnt   <= '0;
            wr_cnt    <= '0;
            state     <= (cfg_pc_num_cfg == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (req_accept && ((req_cnt + MAX_NUM_CFG_WIDTH'(1)) == num_cfg_q)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (wr_cnt == num_cfg_q) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding       <= '0;
      occupancy         <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      pc_err_unexp_rdrs <= 1'b0;
    end else begin
      case ({req_accept, push})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: ;
      endcase
      case ({push, pop})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: ;
      endcase
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (rdrs_valid && (outstanding == '0)) pc_err_unexp_rdrs <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the cleared pointers and occupancy make stale words unreachable.
  always_ff @(posedge clk) begin
    if (push) queue_mem[wr_ptr] <= rdrs_data;
  end

  // Idle cycles drive all-zero so the switch can OR-merge this source with others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cgra_cfg_c2sw_wr_en <= 1'b0;
      cgra_cfg_c2sw_addr  <= '0;
      cgra_cfg_c2sw_data  <= '0;
    end else if (pop) begin
      cgra_cfg_c2sw_wr_en <= 1'b1;
      cgra_cfg_c2sw_addr  <= rd_word[BANK_DATA_WIDTH-1 -: CGRA_CFG_ADDR_WIDTH];
      cgra_cfg_c2sw_data  <= rd_word[CGRA_CFG_DATA_WIDTH-1:0];
    end else begin
      cgra_cfg_c2sw_wr_en <= 1'b0;
      cgra_cfg_c2sw_addr  <= '0;
      cgra_cfg_c2sw_data  <= '0;
    end
  end

`ifdef GLB_PC_DMA_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_dma_cycles       <= '0;
      pc_dma_stall_cycles <= '0;
    end else if (start_fire) begin
      pc_dma_cycles       <= '0;
      pc_dma_stall_cycles <= '0;
    end else begin
      if (pc_busy && (pc_dma_cycles != '1)) pc_dma_cycles <= pc_dma_cycles + 32'd1;
      if (cfg_stall && (occupancy != '0) && (pc_dma_stall_cycles != '1))
        pc_dma_stall_cycles <= pc_dma_stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_glb_tile_pcfg_dma_ctrl.sv
// Scoreboard bench for glb_tile_pcfg_dma_ctrl: expected requests/writes are queued by the stimulus,
// a negedge monitor pops and compares them; a bank responder answers each request two cycles later.
module tb_glb_tile_pcfg_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_pc_dma_mode;
  logic [21:0] cfg_pc_start_addr;
  logic [15:0] cfg_pc_num_cfg;
  logic        pc_start_pulse;
  logic        pc_busy;
  logic        pc_done_pulse;
  logic        rdrq_en;
  logic [21:0] rdrq_addr;
  logic        rdrq_ready;
  logic        rdrs_valid;
  logic [63:0] rdrs_data;
  logic        cfg_stall;
  logic        cgra_cfg_c2sw_wr_en;
  logic        cgra_cfg_c2sw_rd_en;
  logic [31:0] cgra_cfg_c2sw_addr;
  logic [31:0] cgra_cfg_c2sw_data;
  logic        pc_err_unexp_rdrs;
`ifdef GLB_PC_DMA_PERF_EN
  logic [31:0] pc_dma_cycles;
  logic [15:0] pc_dma_stall_cycles;
`endif

  glb_tile_pcfg_dma_ctrl dut (
    .clk                 (clk),
    .reset               (reset),
    .cfg_pc_dma_mode     (cfg_pc_dma_mode),
    .cfg_pc_start_addr   (cfg_pc_start_addr),
    .cfg_pc_num_cfg      (cfg_pc_num_cfg),
    .pc_start_pulse      (pc_start_pulse),
    .pc_busy             (pc_busy),
    .pc_done_pulse       (pc_done_pulse),
    .rdrq_en             (rdrq_en),
    .rdrq_addr           (rdrq_addr),
    .rdrq_ready          (rdrq_ready),
    .rdrs_valid          (rdrs_valid),
    .rdrs_data           (rdrs_data),
    .cfg_stall           (cfg_stall),
    .cgra_cfg_c2sw_wr_en (cgra_cfg_c2sw_wr_en),
    .cgra_cfg_c2sw_rd_en (cgra_cfg_c2sw_rd_en),
    .cgra_cfg_c2sw_addr  (cgra_cfg_c2sw_addr),
    .cgra_cfg_c2sw_data  (cgra_cfg_c2sw_data),
    .pc_err_unexp_rdrs   (pc_err_unexp_rdrs)
`ifdef GLB_PC_DMA_PERF_EN
    ,
    .pc_dma_cycles       (pc_dma_cycles),
    .pc_dma_stall_cycles (pc_dma_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [63:0] word;
  } resp_t;

  logic [21:0] exp_rq[$];
  logic [63:0] exp_wr[$];
  resp_t       pend[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;
  int n_wr     = 0;
  int n_done   = 0;
  int n_hold   = 0;
  int cyc      = 0;
  int inj_cnt  = 0;
  int inj_done = 0;

  function automatic logic [63:0] mk_word(input logic [21:0] a);
    return {32'hA000_0000 + 32'(a), 32'h5000_0000 + 32'(a)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bank model: every accepted request is answered in order two cycles later.
  always @(negedge clk) begin
    if (reset && rdrq_en && rdrq_ready) pend.push_back('{cyc + 2, mk_word(rdrq_addr)});
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    rdrs_valid = 1'b0;
    rdrs_data  = '0;
    if (!reset) pend.delete();
    else if (inj_cnt != inj_done) begin
      rdrs_valid = 1'b1;
      rdrs_data  = 64'hDEAD_BEEF_0000_0000;
      inj_done++;
    end else if (pend.size() != 0 && pend[0].due <= cyc) begin
      rdrs_valid = 1'b1;
      rdrs_data  = pend[0].word;
      void'(pend.pop_front());
    end
  end

  // Monitor: compares every request and config write against the scoreboard queues.
  always @(negedge clk) begin
    if (reset) begin
      if (rdrq_en) begin
        if (exp_rq.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rdrq_unexpected: got request to 0x%0h, expected none", rdrq_addr);
        end else begin
          check("rdrq_addr", 64'(rdrq_addr), 64'(exp_rq[0]));
          if (rdrq_ready) void'(exp_rq.pop_front());
        end
        if (rdrq_ready) n_acc++;
        else n_hold++;
      end
      if (cgra_cfg_c2sw_wr_en) begin
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL wr_unexpected: got 0x%0h_%0h, expected no write",
                   cgra_cfg_c2sw_addr, cgra_cfg_c2sw_data);
        end else begin
          check("cfg_write", {cgra_cfg_c2sw_addr, cgra_cfg_c2sw_data}, exp_wr.pop_front());
        end
        n_wr++;
      end else begin
        check("cfg_idle_zero", {cgra_cfg_c2sw_addr, cgra_cfg_c2sw_data}, 64'h0);
      end
      check("rd_en_tied", 64'(cgra_cfg_c2sw_rd_en), 64'h0);
      if (pc_done_pulse) n_done++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [21:0] b, input logic [15:0] n);
    tick();
    cfg_pc_start_addr = b;
    cfg_pc_num_cfg    = n;
    pc_start_pulse    = 1'b1;
    tick();
    pc_start_pulse    = 1'b0;
  endtask

  // Returns in the first cycle after the target write count is observed.
  task automatic wait_wr(input int target, input bit toggle);
    for (int k = 0; k < 300 && n_wr < target; k++) begin
      tick();
      if (toggle) rdrq_ready = ~rdrq_ready;
    end
    check("write_count", 64'(n_wr), 64'(target));
  endtask

  task automatic finish_op(input string name, input int done0);
    check({name, "_done_pulse"}, 64'(pc_done_pulse), 64'h1);
    tick();
    check({name, "_done_once"}, 64'(n_done - done0), 64'h1);
    check({name, "_idle_busy"}, 64'(pc_busy), 64'h0);
  endtask

  initial begin
    int acc0, wr0, done0;
    reset = 1'b0; cfg_pc_dma_mode = 1'b1; cfg_pc_start_addr = '0; cfg_pc_num_cfg = '0;
    pc_start_pulse = 1'b0; rdrq_ready = 1'b1; cfg_stall = 1'b0;
    rdrs_valid = 1'b0; rdrs_data = '0;
    repeat (3) tick();
    check("reset_outputs", {rdrq_en, rdrq_addr, pc_busy, pc_done_pulse, cgra_cfg_c2sw_wr_en,
          pc_err_unexp_rdrs, cgra_cfg_c2sw_addr}, 64'h0);
    reset = 1'b1;
    tick();
    check("post_reset_busy", 64'(pc_busy), 64'h0);

    // Basic run of three words.
    exp_rq = '{22'h100, 22'h108, 22'h110};
    exp_wr = '{64'hA000_0100_5000_0100, 64'hA000_0108_5000_0108, 64'hA000_0110_5000_0110};
    wr0 = n_wr; done0 = n_done;
    start_op(22'h100, 16'd3);
    check("basic_busy", 64'(pc_busy), 64'h1);
    wait_wr(wr0 + 3, 1'b0);
    finish_op("basic", done0);

    // Zero count: DONE immediately, busy for exactly one cycle.
    acc0 = n_acc; done0 = n_done;
    start_op(22'h400, 16'd0);
    check("zero_busy", 64'(pc_busy), 64'h1);
    check("zero_done", 64'(pc_done_pulse), 64'h1);
    tick();
    check("zero_busy_after", 64'(pc_busy), 64'h0);
    check("zero_no_requests", 64'(n_acc - acc0), 64'h0);
    check("zero_done_once", 64'(n_done - done0), 64'h1);

    // Stall and backpressure: credit limit caps requests at the queue depth.
    for (int i = 0; i < 10; i++) begin
      exp_rq.push_back(22'h1000 + 22'(8 * i));
      exp_wr.push_back(mk_word(22'h1000 + 22'(8 * i)));
    end
    acc0 = n_acc; wr0 = n_wr; done0 = n_done;
    tick();
    cfg_pc_start_addr = 22'h1000; cfg_pc_num_cfg = 16'd10;
    pc_start_pulse = 1'b1; cfg_stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      pc_start_pulse = 1'b0;
    end
    check("stall_req_count", 64'(n_acc - acc0), 64'h4);
    check("stall_rdrq_off", 64'(rdrq_en), 64'h0);
    check("stall_no_writes", 64'(n_wr - wr0), 64'h0);
    cfg_stall = 1'b0;
    wait_wr(wr0 + 10, 1'b0);
    finish_op("stall", done0);
`ifdef GLB_PC_DMA_PERF_EN
    check("perf_stall_cycles", 64'(pc_dma_stall_cycles), 64'd16);
`endif

    // Arbitration and address wrap with toggling ready.
    exp_rq = '{22'h3F_FFF8, 22'h00_0000};
    exp_wr = '{64'hA03F_FFF8_503F_FFF8, 64'hA000_0000_5000_0000};
    wr0 = n_wr; done0 = n_done; n_hold = 0;
    rdrq_ready = 1'b0;
    start_op(22'h3F_FFF8, 16'd2);
    wait_wr(wr0 + 2, 1'b1);
    rdrq_ready = 1'b1;
    finish_op("wrap", done0);
    check("wrap_held_cycles", 64'(n_hold), 64'h2);

    // Unexpected response while idle sets the sticky flag.
    check("err_clear", 64'(pc_err_unexp_rdrs), 64'h0);
    inj_cnt++;
    repeat (3) tick();
    check("err_set", 64'(pc_err_unexp_rdrs), 64'h1);

    // Start with DMA mode off is ignored.
    acc0 = n_acc;
    cfg_pc_dma_mode = 1'b0;
    start_op(22'h300, 16'd2);
    check("mode0_busy", 64'(pc_busy), 64'h0);
    repeat (5) tick();
    check("mode0_no_requests", 64'(n_acc - acc0), 64'h0);
    cfg_pc_dma_mode = 1'b1;

    // A second start during RUN is ignored.
    exp_rq = '{22'h200, 22'h208, 22'h210};
    exp_wr = '{64'hA000_0200_5000_0200, 64'hA000_0208_5000_0208, 64'hA000_0210_5000_0210};
    wr0 = n_wr; done0 = n_done;
    start_op(22'h200, 16'd3);
    cfg_pc_start_addr = 22'h800; cfg_pc_num_cfg = 16'd5; pc_start_pulse = 1'b1;
    tick();
    pc_start_pulse = 1'b0;
    wait_wr(wr0 + 3, 1'b0);
    finish_op("restart", done0);
    repeat (5) tick();
    check("restart_single_done", 64'(n_done - done0), 64'h1);
    check("err_sticky", 64'(pc_err_unexp_rdrs), 64'h1);

    // Reset in DRAIN aborts immediately.
    for (int i = 0; i < 4; i++) exp_rq.push_back(22'h40 + 22'(8 * i));
    acc0 = n_acc;
    cfg_stall = 1'b1;
    start_op(22'h40, 16'd4);
    for (int k = 0; k < 50 && n_acc < acc0 + 4; k++) tick();
    check("abort_req_count", 64'(n_acc - acc0), 64'h4);
    tick();
    check("abort_busy_before", 64'(pc_busy), 64'h1);
    #1 reset = 1'b0;
    #1;
    check("abort_outputs", {rdrq_en, rdrq_addr, pc_busy, pc_done_pulse, cgra_cfg_c2sw_wr_en,
          pc_err_unexp_rdrs, cgra_cfg_c2sw_addr}, 64'h0);
    check("abort_data", 64'(cgra_cfg_c2sw_data), 64'h0);
    exp_wr.delete();
    repeat (2) tick();
    reset = 1'b1; cfg_stall = 1'b0;
    tick();
    check("abort_err_cleared", 64'(pc_err_unexp_rdrs), 64'h0);

    // Clean run after the abort.
    exp_rq = '{22'h000, 22'h008};
    exp_wr = '{64'hA000_0000_5000_0000, 64'hA000_0008_5000_0008};
    wr0 = n_wr; done0 = n_done;
    start_op(22'h000, 16'd2);
    wait_wr(wr0 + 2, 1'b0);
    finish_op("clean", done0);
    repeat (4) tick();
    check("exp_rq_empty", 64'(exp_rq.size()), 64'h0);
    check("exp_wr_empty", 64'(exp_wr.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
